// File: rtl/regfile_mp_clr_if.sv
// Bus bundle for regfile_mp_clr: two read ports, two write ports and the clear-engine handshake.
// Clear handshake: clr_req is accepted on any edge where clr_busy is low; while clr_busy is high, requests are ignored.
interface regfile_mp_clr_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              we0;
  logic [ADDR_W-1:0] waddr0;
  logic [DATA_W-1:0] wdata0;
  logic              we1;
  logic [ADDR_W-1:0] waddr1;
  logic [DATA_W-1:0] wdata1;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;
  logic              dbg_clearing;

  modport master (
    output rd_addr_a, rd_addr_b, we0, waddr0, wdata0, we1, waddr1, wdata1, clr_req,
    input  rd_data_a, rd_data_b, clr_busy, clr_done, dbg_clearing
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, we0, waddr0, wdata0, we1, waddr1, wdata1, clr_req,
    output rd_data_a, rd_data_b, clr_busy, clr_done, dbg_clearing
  );
endinterface

// File: rtl/regfile_mp_clr.sv
// 2-read/2-write register file with priority write port 1, optional zero register and a sequential clear sweep.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp_clr #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst,
  regfile_mp_clr_if.slave     bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              clearing;
  logic              wr0_ok;
  logic              wr1_ok;
  logic              zero_a;
  logic              zero_b;

  assign clearing         = (state == CLEAR);
  assign bus.dbg_clearing = clearing;

  // Writes that will actually land this edge; also the only writes eligible for forwarding.
  assign wr0_ok = bus.we0 && !rst && !clearing && !((ZERO_REG != 0) && (bus.waddr0 == '0));
  assign wr1_ok = bus.we1 && !rst && !clearing && !((ZERO_REG != 0) && (bus.waddr1 == '0));

  assign zero_a = (ZERO_REG != 0) && (bus.rd_addr_a == '0);
  assign zero_b = (ZERO_REG != 0) && (bus.rd_addr_b == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= CLEAR;
      cnt          <= '0;
      bus.clr_busy <= 1'b1;
      bus.clr_done <= 1'b0;
    end else begin
      bus.clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state        <= CLEAR;
            cnt          <= '0;
            bus.clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state        <= IDLE;
            bus.clr_busy <= 1'b0;
            bus.clr_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single write process keeps the array RAM-mappable; port 1 is written last so it wins on a collision.
  always_ff @(posedge clk) begin
    if (!rst && clearing) mem[cnt] <= '0;
    if (wr0_ok) mem[bus.waddr0] <= bus.wdata0;
    if (wr1_ok) mem[bus.waddr1] <= bus.wdata1;
  end

  always_comb begin
    bus.rd_data_a = '0;
    bus.rd_data_b = '0;
    if (!clearing) begin
      bus.rd_data_a = mem[bus.rd_addr_a];
      bus.rd_data_b = mem[bus.rd_addr_b];
`ifdef REGFILE_BYPASS_EN
      if (wr0_ok && (bus.waddr0 == bus.rd_addr_a)) bus.rd_data_a = bus.wdata0;
      if (wr0_ok && (bus.waddr0 == bus.rd_addr_b)) bus.rd_data_b = bus.wdata0;
      if (wr1_ok && (bus.waddr1 == bus.rd_addr_a)) bus.rd_data_a = bus.wdata1;
      if (wr1_ok && (bus.waddr1 == bus.rd_addr_b)) bus.rd_data_b = bus.wdata1;
`endif
      if (zero_a) bus.rd_data_a = '0;
      if (zero_b) bus.rd_data_b = '0;
    end
  end
endmodule

// File: tb/tb_regfile_mp_clr.sv
// Bench for regfile_mp_clr: one DUT with ZERO_REG=1 and one with ZERO_REG=0 driven by the same stimulus.
module tb_regfile_mp_clr;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_clr_if #(.DATA_W(DW), .ADDR_W(AW)) bus_z ();
  regfile_mp_clr_if #(.DATA_W(DW), .ADDR_W(AW)) bus_n ();

  regfile_mp_clr #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut_z (.clk(clk), .rst(rst), .bus(bus_z.slave));
  regfile_mp_clr #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n.slave));

  assign bus_n.rd_addr_a = bus_z.rd_addr_a;
  assign bus_n.rd_addr_b = bus_z.rd_addr_b;
  assign bus_n.we0       = bus_z.we0;
  assign bus_n.waddr0    = bus_z.waddr0;
  assign bus_n.wdata0    = bus_z.wdata0;
  assign bus_n.we1       = bus_z.we1;
  assign bus_n.waddr1    = bus_z.waddr1;
  assign bus_n.wdata1    = bus_z.wdata1;
  assign bus_n.clr_req   = bus_z.clr_req;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: k=0 is the zero-register instance, k=1 the plain one.
  logic [DW-1:0] m_mem [2][DEPTH];
  int            sweep_left = 0;
  bit            exp_done   = 1'b0;
  bit            mdl_ok     = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int k, input logic [AW-1:0] a);
    if (sweep_left > 0) return '0;
    if (k == 0 && a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus_z.we1 && bus_z.waddr1 == a) return bus_z.wdata1;
    if (bus_z.we0 && bus_z.waddr0 == a) return bus_z.wdata0;
`endif
    return m_mem[k][a];
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_mem[1][a] = d;
    if (a != 0) m_mem[0][a] = d;
  endtask

  // Sweep modelled as a countdown; memory is zeroed as a whole when it completes.
  task automatic model_edge();
    if (rst) begin
      sweep_left = DEPTH;
      exp_done   = 1'b0;
      mdl_ok     = 1'b1;
    end else if (sweep_left > 0) begin
      exp_done = (sweep_left == 1);
      sweep_left--;
      if (sweep_left == 0)
        for (int i = 0; i < DEPTH; i++) begin
          m_mem[0][i] = '0;
          m_mem[1][i] = '0;
        end
    end else begin
      exp_done = 1'b0;
      if (bus_z.we0) model_write(bus_z.waddr0, bus_z.wdata0);
      if (bus_z.we1) model_write(bus_z.waddr1, bus_z.wdata1);
      if (bus_z.clr_req) sweep_left = DEPTH;
    end
  endtask

  // Inputs are set at the negedge; reads checked just after, flags checked at the next negedge.
  task automatic cycle();
    #1;
    if (mdl_ok && !rst) begin
      check("rd_a_zr",  bus_z.rd_data_a, exp_rd(0, bus_z.rd_addr_a));
      check("rd_b_zr",  bus_z.rd_data_b, exp_rd(0, bus_z.rd_addr_b));
      check("rd_a_nzr", bus_n.rd_data_a, exp_rd(1, bus_z.rd_addr_a));
      check("rd_b_nzr", bus_n.rd_data_b, exp_rd(1, bus_z.rd_addr_b));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (mdl_ok) begin
      check("busy_zr", DW'(bus_z.clr_busy),     DW'(sweep_left > 0));
      check("busy_nzr", DW'(bus_n.clr_busy),    DW'(sweep_left > 0));
      check("done_zr", DW'(bus_z.clr_done),     DW'(exp_done));
      check("done_nzr", DW'(bus_n.clr_done),    DW'(exp_done));
      check("dbg_zr",  DW'(bus_z.dbg_clearing), DW'(sweep_left > 0));
      check("dbg_nzr", DW'(bus_n.dbg_clearing), DW'(sweep_left > 0));
    end
  endtask

  task automatic idle_inputs();
    bus_z.we0     = 1'b0;
    bus_z.we1     = 1'b0;
    bus_z.clr_req = 1'b0;
  endtask

  task automatic rand_inputs(input int req_pct);
    bus_z.rd_addr_a = AW'($urandom_range(0, DEPTH - 1));
    bus_z.rd_addr_b = AW'($urandom_range(0, DEPTH - 1));
    bus_z.we0       = 1'($urandom_range(0, 1));
    bus_z.waddr0    = AW'($urandom_range(0, DEPTH - 1));
    bus_z.wdata0    = $urandom;
    bus_z.we1       = 1'($urandom_range(0, 1));
    bus_z.waddr1    = ($urandom_range(0, 3) == 0) ? bus_z.waddr0 : AW'($urandom_range(0, DEPTH - 1));
    bus_z.wdata1    = $urandom;
    bus_z.clr_req   = ($urandom_range(1, 100) <= req_pct);
  endtask

  // Runs cycles while busy is sampled high; bounded so a stuck sweep still ends.
  task automatic run_sweep(input bit noisy, output int busy_n, output int done_n);
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < 200 && bus_z.clr_busy; i++) begin
      busy_n++;
      if (noisy) rand_inputs(30);
      cycle();
      done_n += int'(bus_z.clr_done);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) begin
      bus_z.rd_addr_a = AW'(i);
      bus_z.rd_addr_b = AW'(DEPTH - 1 - i);
      cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, done_n;
    logic [DW-1:0] exp_v;

    bus_z.rd_addr_a = '0; bus_z.rd_addr_b = '0;
    bus_z.waddr0 = '0; bus_z.wdata0 = '0; bus_z.waddr1 = '0; bus_z.wdata1 = '0;
    idle_inputs();
    @(negedge clk);

    // Reset, then the power-on sweep
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    run_sweep(1'b0, busy_n, done_n);
    check("reset_busy_len", DW'(busy_n), DW'(DEPTH));
    check("reset_done_cnt", DW'(done_n), 32'd1);
    read_all();

    // Same-address collision: port 1 wins
    bus_z.we0 = 1'b1; bus_z.waddr0 = 5'd5; bus_z.wdata0 = 32'h1111_1111;
    bus_z.we1 = 1'b1; bus_z.waddr1 = 5'd5; bus_z.wdata1 = 32'h2222_2222;
    cycle();
    idle_inputs();
    bus_z.rd_addr_a = 5'd5;
    #1 check("prio_addr5", bus_z.rd_data_a, 32'h2222_2222);
    cycle();

    // Distinct addresses: both land
    bus_z.we0 = 1'b1; bus_z.waddr0 = 5'd7; bus_z.wdata0 = 32'h0707_0707;
    bus_z.we1 = 1'b1; bus_z.waddr1 = 5'd9; bus_z.wdata1 = 32'h0909_0909;
    cycle();
    idle_inputs();
    bus_z.rd_addr_a = 5'd7; bus_z.rd_addr_b = 5'd9;
    #1;
    check("dual_wr_7", bus_z.rd_data_a, 32'h0707_0707);
    check("dual_wr_9", bus_z.rd_data_b, 32'h0909_0909);
    cycle();

    // Zero register
    bus_z.we0 = 1'b1; bus_z.waddr0 = 5'd0; bus_z.wdata0 = 32'hDEAD_BEEF;
    cycle();
    idle_inputs();
    bus_z.rd_addr_a = 5'd0; bus_z.rd_addr_b = 5'd0;
    #1;
    check("zero_reg_a", bus_z.rd_data_a, 32'h0);
    check("zero_reg_b", bus_z.rd_data_b, 32'h0);
    check("plain_reg0", bus_n.rd_data_a, 32'hDEAD_BEEF);
    cycle();

    // Same-cycle read of a write target
    bus_z.we0 = 1'b1; bus_z.waddr0 = 5'd3; bus_z.wdata0 = 32'hCAFE_F00D;
    bus_z.rd_addr_b = 5'd3;
`ifdef REGFILE_BYPASS_EN
    exp_v = 32'hCAFE_F00D;
`else
    exp_v = 32'h0;
`endif
    #1 check("same_cycle_rd", bus_z.rd_data_b, exp_v);
    cycle();
    idle_inputs();
    #1 check("next_cycle_rd", bus_z.rd_data_b, 32'hCAFE_F00D);
    cycle();

    // Fill 1..31, then clear with noisy writes and repeated requests mid-sweep
    for (int i = 1; i < DEPTH; i += 2) begin
      bus_z.we0 = 1'b1; bus_z.waddr0 = AW'(i);     bus_z.wdata0 = $urandom | 32'h1;
      bus_z.we1 = (i + 1 < DEPTH); bus_z.waddr1 = AW'(i + 1); bus_z.wdata1 = $urandom | 32'h1;
      cycle();
    end
    idle_inputs();
    read_all();
    bus_z.clr_req = 1'b1;
    cycle();
    run_sweep(1'b1, busy_n, done_n);
    check("clr_busy_len", DW'(busy_n), DW'(DEPTH));
    check("clr_done_cnt", DW'(done_n), 32'd1);
    read_all();

    // Reset in the middle of a sweep
    bus_z.clr_req = 1'b1;
    cycle();
    idle_inputs();
    done_n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      done_n += int'(bus_z.clr_done);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    done_n += int'(bus_z.clr_done);
    check("abort_no_done", DW'(done_n), 32'd0);
    run_sweep(1'b0, busy_n, done_n);
    check("abort_busy_len", DW'(busy_n), DW'(DEPTH));
    check("abort_done_cnt", DW'(done_n), 32'd1);

    // Random traffic with occasional clear requests
    for (int i = 0; i < 400; i++) begin
      rand_inputs(2);
      cycle();
    end
    idle_inputs();
    for (int i = 0; i < 40; i++) cycle();
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
